// File: rtl/sample_interpolator.sv
// Upsampling interpolator: linear ramps between successive low-rate samples, one value per out_tick.
// Build option: define INTERP_LINEAR_EN for linear interpolation; leave it undefined for zero-order hold.
module sample_interpolator #(
  parameter int BITS_ADC  = 8,
  parameter int BITS_ACUM = 12
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [$clog2(BITS_ACUM-BITS_ADC)-1:0]   k,
  input  logic [BITS_ADC-1:0]                     sample_in,
  input  logic                                    rdy_in,
  input  logic                                    out_tick,
  output logic [BITS_ADC-1:0]                     sample_out,
  output logic                                    rdy_out,
  output logic                                    overrun,
  output logic                                    underrun
);

  localparam int KW = $clog2(BITS_ACUM-BITS_ADC);
  localparam int AW = BITS_ACUM + 1;
  localparam int DW = BITS_ADC + 1;
  localparam int CW = BITS_ACUM - BITS_ADC + 1;

`ifdef INTERP_LINEAR_EN
  localparam bit LINEAR = 1'b1;
`else
  localparam bit LINEAR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PRIME, RUN, HOLD} state_t;

  state_t                  state;
  logic [BITS_ADC-1:0]     prev;
  logic [KW-1:0]           k_lat;
  logic signed [AW-1:0]    acc;
  logic signed [DW-1:0]    delta;
  logic [CW-1:0]           count;

  // Accumulator holds value * 2^k_lat; arithmetic shift gives the floor.
  function automatic logic [BITS_ADC-1:0] seg_value(input logic signed [AW-1:0] a,
                                                    input logic [KW-1:0] sh);
    logic signed [AW-1:0] s;
    s = a >>> sh;
    return s[BITS_ADC-1:0];
  endfunction

  function automatic logic signed [AW-1:0] base_acc(input logic [BITS_ADC-1:0] p,
                                                    input logic [KW-1:0] sh);
    return $signed({{(AW-BITS_ADC){1'b0}}, p}) <<< sh;
  endfunction

  // Zero-order hold keeps the slope at zero so every output repeats the segment start.
  function automatic logic signed [DW-1:0] seg_delta(input logic [BITS_ADC-1:0] tgt,
                                                     input logic [BITS_ADC-1:0] p);
    logic signed [DW-1:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, p});
    return LINEAR ? d : '0;
  endfunction

  function automatic logic signed [AW-1:0] acc_step(input logic signed [AW-1:0] a,
                                                   input logic signed [DW-1:0] d);
    return a + $signed({{(AW-DW){d[DW-1]}}, d});
  endfunction

  // Output register stage: outputs use pre-update state; a concurrent rdy_in reload wins for state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      k_lat      <= '0;
      acc        <= '0;
      delta      <= '0;
      count      <= '0;
      sample_out <= '0;
      rdy_out    <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      rdy_out  <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      if (state == IDLE) begin
        if (rdy_in) begin
          prev  <= sample_in;
          state <= PRIME;
        end
      end else begin
        if (out_tick) begin
          rdy_out <= 1'b1;
          case (state)
            PRIME: sample_out <= prev;
            RUN: begin
              sample_out <= seg_value(acc, k_lat);
              acc        <= acc_step(acc, delta);
              count      <= count - CW'(1);
              if (count == CW'(1))
                state <= HOLD;
            end
            HOLD: begin
              sample_out <= prev;
              underrun   <= 1'b1;
            end
            default: ;
          endcase
        end
        if (rdy_in) begin
          // Overrun only if values remain after any tick consumed this cycle.
          overrun <= (state == RUN) && (count > CW'(out_tick));
          k_lat   <= k;
          delta   <= seg_delta(sample_in, prev);
          acc     <= base_acc(prev, k);
          count   <= CW'(1) << k;
          prev    <= sample_in;
          state   <= RUN;
        end
      end
    end
  end

endmodule
